// File: rtl/aqed_out_checker_if.sv
// Write-tag and read-beat bundle between the bench/core side and the
// A-QED output checker, with the checker's status outputs.
interface aqed_out_checker_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 17
);
    logic                  in_valid;
    logic                  in_orig;
    logic                  in_dup;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  qed_done;
    logic                  qed_check;
    logic                  orig_seen;
    logic [CNT_WIDTH-1:0]  in_cnt;
    logic [CNT_WIDTH-1:0]  out_cnt;
    logic                  rb_violation;

    modport master (
        output in_valid, in_orig, in_dup, out_data, out_valid,
        input  qed_done, qed_check, orig_seen, in_cnt, out_cnt,
        input  rb_violation
    );

    modport slave (
        input  in_valid, in_orig, in_dup, out_data, out_valid,
        output qed_done, qed_check, orig_seen, in_cnt, out_cnt,
        output rb_violation
    );
endinterface

// File: rtl/aqed_out_checker.sv
// A-QED output-side consistency checker: tags original/duplicate writes and
// compares their read beats. AQED_RB_CHECK_EN adds a response-bound timer.
module aqed_out_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 17,
    parameter int RB_LIMIT   = 64
) (
    input logic              clk,
    input logic              reset,
    input logic              clk_en,
    aqed_out_checker_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ORIG,
        S_WAIT_DUP,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [CNT_WIDTH-1:0]  in_cnt, out_cnt;
    logic [CNT_WIDTH-1:0]  orig_idx, dup_idx;
    logic                  orig_tagged, dup_tagged;
    logic [DATA_WIDTH-1:0] orig_data;
    logic                  orig_seen, qed_check;
    logic                  in_sat, out_sat;
    logic                  tag_orig, tag_dup;
    logic                  orig_hit, dup_hit;

    assign in_sat  = &in_cnt;
    assign out_sat = &out_cnt;

    // A beat carrying both flags counts only as the original.
    assign tag_orig = bus.in_valid & bus.in_orig & ~orig_tagged & ~in_sat;
    assign tag_dup  = bus.in_valid & bus.in_dup & ~bus.in_orig
                    & orig_tagged & ~dup_tagged & ~in_sat;

    assign orig_hit = (state == S_WAIT_ORIG) & bus.out_valid
                    & (out_cnt == orig_idx);
    assign dup_hit  = (state == S_WAIT_DUP) & dup_tagged & bus.out_valid
                    & (out_cnt == dup_idx);

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:      if (tag_orig) state_n = S_WAIT_ORIG;
            S_WAIT_ORIG: if (orig_hit) state_n = S_WAIT_DUP;
            S_WAIT_DUP:  if (dup_hit)  state_n = S_DONE;
            S_DONE:      state_n = S_DONE;
            default:     state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            in_cnt      <= '0;
            out_cnt     <= '0;
            orig_idx    <= '0;
            dup_idx     <= '0;
            orig_tagged <= 1'b0;
            dup_tagged  <= 1'b0;
            orig_data   <= '0;
            orig_seen   <= 1'b0;
            qed_check   <= 1'b0;
        end else if (clk_en) begin
            state <= state_n;
            if (bus.in_valid && !in_sat)
                in_cnt <= in_cnt + CNT_WIDTH'(1);
            if (bus.out_valid && !out_sat)
                out_cnt <= out_cnt + CNT_WIDTH'(1);
            if (tag_orig) begin
                orig_idx    <= in_cnt;
                orig_tagged <= 1'b1;
            end
            if (tag_dup) begin
                dup_idx    <= in_cnt;
                dup_tagged <= 1'b1;
            end
            if (orig_hit) begin
                orig_data <= bus.out_data;
                orig_seen <= 1'b1;
            end
            if (dup_hit)
                qed_check <= (bus.out_data == orig_data);
        end
    end

    assign bus.qed_done  = (state == S_DONE);
    assign bus.qed_check = qed_check;
    assign bus.orig_seen = orig_seen;
    assign bus.in_cnt    = in_cnt;
    assign bus.out_cnt   = out_cnt;

`ifdef AQED_RB_CHECK_EN
    localparam int RB_W = $clog2(RB_LIMIT + 1);
    localparam logic [RB_W-1:0] RB_MAX = RB_W'(RB_LIMIT);

    logic [RB_W-1:0] rb_timer;
    logic            rb_violation;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rb_timer     <= '0;
            rb_violation <= 1'b0;
        end else if (clk_en) begin
            if (state != S_WAIT_ORIG && state_n == S_WAIT_ORIG)
                rb_timer <= '0;
            else if (state == S_WAIT_ORIG && rb_timer != RB_MAX)
                rb_timer <= rb_timer + RB_W'(1);
            if (state == S_WAIT_ORIG && rb_timer == RB_MAX)
                rb_violation <= 1'b1;
        end
    end

    assign bus.rb_violation = rb_violation;
`else
    assign bus.rb_violation = 1'b0;
`endif
endmodule
